// File: rtl/cam_bus_emulator.sv
// rtl/cam_bus_emulator.sv - camera parallel bus transmitter driven from on-chip test patterns
module cam_bus_emulator #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done
);

    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W     = $clog2(LINE_LEN);
    localparam int MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_L     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LINE_W    = $clog2(MAX_L + 1);
    localparam int BAR_BYTES = H_ACTIVE / 4;
    localparam int BAR_W     = $clog2(BAR_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [4:0]          frame_cnt_q, frame_cnt_d;
    logic [1:0]          pat_q, pat_d;
    logic [15:0]         solid_q, solid_d;
    logic [BAR_W-1:0]    bar_byte_q, bar_byte_d;
    logic [2:0]          bar_idx_q, bar_idx_d;

    logic                vsync_d, href_d, done_d;
    logic [7:0]          data_d;

    logic                col_last, line_last, state_end, frame_last, start;
    int                  lines_n;
    logic [4:0]          x;
    logic [5:0]          y;
    logic [15:0]         pixel;

    // State register: position counters, latched frame settings and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
            bar_byte_q  <= '0;
            bar_idx_q   <= '0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= '0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            solid_q     <= solid_d;
            bar_byte_q  <= bar_byte_d;
            bar_idx_q   <= bar_idx_d;
            cam_vsync   <= vsync_d;
            cam_href    <= href_d;
            cam_data    <= data_d;
            frame_done  <= done_d;
        end
    end

    // Next-state: the _d position is what the outputs show in the following cycle.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        bar_byte_d  = '0;
        bar_idx_d   = '0;
        start       = 1'b0;

        case (state_q)
            S_VSYNC:  lines_n = VSYNC_LINES;
            S_VBACK:  lines_n = V_BACK;
            S_ACTIVE: lines_n = V_ACTIVE;
            S_VFRONT: lines_n = V_FRONT;
            default:  lines_n = 0;
        endcase

        col_last   = (int'(col_q) == LINE_LEN - 1);
        line_last  = (int'(line_q) == lines_n - 1);
        state_end  = (state_q != S_IDLE) && col_last && line_last;
        frame_last = state_end && ((state_q == S_VFRONT) ||
                                   ((state_q == S_ACTIVE) && (V_FRONT == 0)));

        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                start   = 1'b1;
            end
        end else begin
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last)
                line_d = line_last ? '0 : line_q + LINE_W'(1);
            if (state_end) begin
                case (state_q)
                    S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = (V_FRONT > 0) ? S_VFRONT :
                                        (enable ? S_VSYNC : S_IDLE);
                    default:  state_d = enable ? S_VSYNC : S_IDLE;
                endcase
            end
            if (frame_last) begin
                frame_cnt_d = frame_cnt_q + 5'd1;
                start       = enable;
            end
        end

        if (start) begin
            pat_d   = pattern_sel;
            solid_d = solid_color;
        end

        // Bar index tracked by a byte counter so no divider is needed.
        if (col_d != '0) begin
            if (bar_byte_q == BAR_W'(BAR_BYTES - 1)) begin
                bar_byte_d = '0;
                bar_idx_d  = bar_idx_q + 3'd1;
            end else begin
                bar_byte_d = bar_byte_q + BAR_W'(1);
                bar_idx_d  = bar_idx_q;
            end
        end
    end

    // Output decode from the next position, registered in the state process.
    always_comb begin
        x       = 5'(col_d >> 1);
        y       = 6'(line_d);
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (int'(col_d) < 2 * H_ACTIVE);
        done_d  = (int'(col_d) == LINE_LEN - 1) &&
                  (((state_d == S_VFRONT) && (int'(line_d) == V_FRONT - 1)) ||
                   ((V_FRONT == 0) && (state_d == S_ACTIVE) &&
                    (int'(line_d) == V_ACTIVE - 1)));

        case (pat_d)
            2'd0: begin
                case (bar_idx_d)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = {x, y, frame_cnt_d};
            2'd2:    pixel = solid_d;
            default: pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
        endcase

        if (!href_d)
            data_d = 8'h00;
        else if (col_d[0])
            data_d = pixel[7:0];
        else
            data_d = pixel[15:8];
    end

endmodule

// File: tb/tb_cam_bus_emulator.sv
// tb/tb_cam_bus_emulator.sv - randomized frame-position model check of cam_bus_emulator
module tb_cam_bus_emulator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'h0;

    logic        vs0, hr0, dn0, vs1, hr1, dn1;
    logic [7:0]  dt0, dt1;

    int total = 0;
    int bad = 0;
    int cur = 0;

    // Geometry of the two instances: {H_ACTIVE, V_ACTIVE, H_BLANK, VSYNC, V_BACK, V_FRONT}
    int g_ha[2] = '{8, 16};
    int g_va[2] = '{4, 16};
    int g_hb[2] = '{4, 4};
    int g_vs[2] = '{1, 1};
    int g_vb[2] = '{1, 1};
    int g_vf[2] = '{1, 1};

    bit m_run[2];
    int m_pos[2];
    int m_fc[2];
    int m_pat[2];
    int m_solid[2];

    logic [7:0] bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                   8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    always #20 clk = ~clk;

    cam_bus_emulator #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
                       .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .cam_vsync(vs0), .cam_href(hr0),
        .cam_data(dt0), .frame_done(dn0)
    );

    cam_bus_emulator #(.H_ACTIVE(16), .V_ACTIVE(16), .H_BLANK(4),
                       .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .cam_vsync(vs1), .cam_href(hr1),
        .cam_data(dt1), .frame_done(dn1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int frame_len(input int i);
        return (g_vs[i] + g_vb[i] + g_va[i] + g_vf[i]) * (2 * g_ha[i] + g_hb[i]);
    endfunction

    // Expected {vsync, href, done, data} from the byte position inside the frame.
    function automatic logic [10:0] model(input int i);
        int ll, line, col, x, y, pix;
        bit vs, act, dn;
        logic [7:0] d;
        int bars [8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0, 'hF81F, 'hF800, 'h001F, 'h0000};
        if (!m_run[i]) return 11'd0;
        ll   = 2 * g_ha[i] + g_hb[i];
        line = m_pos[i] / ll;
        col  = m_pos[i] % ll;
        vs   = line < g_vs[i];
        act  = (line >= g_vs[i] + g_vb[i]) && (line < g_vs[i] + g_vb[i] + g_va[i]) &&
               (col < 2 * g_ha[i]);
        y    = line - g_vs[i] - g_vb[i];
        x    = col / 2;
        case (m_pat[i])
            0:       pix = bars[x / (g_ha[i] / 8)];
            1:       pix = ((x % 32) * 2048) + ((y % 64) * 32) + (m_fc[i] % 32);
            2:       pix = m_solid[i];
            default: pix = (((x / 8) % 2) != ((y / 8) % 2)) ? 'hFFFF : 0;
        endcase
        d  = act ? ((col % 2 == 0) ? 8'(pix / 256) : 8'(pix % 256)) : 8'h00;
        dn = (m_pos[i] == frame_len(i) - 1);
        return {vs, act, dn, d};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_run[i] <= 1'b0;
                m_pos[i] <= 0;
                m_fc[i]  <= 0;
            end else if (!m_run[i]) begin
                if (enable) begin
                    m_run[i]   <= 1'b1;
                    m_pos[i]   <= 0;
                    m_pat[i]   <= int'(pattern_sel);
                    m_solid[i] <= int'(solid_color);
                end
            end else if (m_pos[i] == frame_len(i) - 1) begin
                m_fc[i] <= (m_fc[i] + 1) % 32;
                m_pos[i] <= 0;
                if (enable) begin
                    m_pat[i]   <= int'(pattern_sel);
                    m_solid[i] <= int'(solid_color);
                end else begin
                    m_run[i] <= 1'b0;
                end
            end else begin
                m_pos[i] <= m_pos[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("dut0_outputs", {vs0, hr0, dn0, dt0}, model(0));
        check("dut2_outputs", {vs1, hr1, dn1, dt1}, model(1));
    end

    task automatic goto(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    initial begin
        enable      = 1'b1;
        pattern_sel = 2'd2;
        solid_color = 16'hABCD;
        repeat (3) @(negedge clk);
        check("reset_outputs", {vs0, hr0, dn0, dt0}, 11'd0);
        reset_n = 1'b1;
        cur = 0;

        goto(1);   check("vsync_rise", vs0, 1'b1);
        goto(20);  check("vsync_last", vs0, 1'b1);
        goto(21);  check("vsync_fall", vs0, 1'b0);
        goto(41);  check("solid_hi", {hr0, dt0}, {1'b1, 8'hAB});
        goto(42);  check("solid_lo", {hr0, dt0}, {1'b1, 8'hCD});
        goto(56);  check("href_last", hr0, 1'b1);
        goto(57);  check("href_blank", {hr0, dt0}, 9'd0);
        goto(100); pattern_sel = 2'd0;
        goto(101); check("midframe_ignored", dt0, 8'hAB);
        goto(140); check("frame_done", dn0, 1'b1);
        goto(141); check("back_to_back", {vs0, dn0}, 2'b10);
        for (int i = 0; i < 16; i++) begin
            goto(181 + i);
            check("bars", dt0, bar_bytes[i]);
        end
        goto(200); pattern_sel = 2'd1;
        goto(371); check("grad_hi_f2", dt0, 8'h28);
        goto(372); check("grad_lo_f2", dt0, 8'h42);
        goto(400); pattern_sel = 2'd3;
        goto(1461); enable = 1'b0;
        goto(1540); check("done_after_drop", dn0, 1'b1);
        goto(1545); check("idle_after_drop", {vs0, hr0, dn0, dt0}, 11'd0);
        goto(2100);
        pattern_sel = 2'd1;
        enable = 1'b1;
        for (int k = 0; k < 500 && !hr0; k++) @(negedge clk);
        check("href_seen", hr0, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {vs0, hr0, dn0, dt0, vs1, hr1, dn1, dt1}, 22'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cur = 0;
        goto(1);   check("restart_vsync", vs0, 1'b1);
        goto(91);  check("grad_hi_f0", dt0, 8'h28);
        goto(92);  check("grad_lo_f0", dt0, 8'h40);

        for (int n = 0; n < 8000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) solid_color = 16'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 2499) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
